// File: rtl/up_counter.sv
// Free-running binary up-counter that wraps modulo MODULUS.
// Asynchronous active-low reset; cout is driven straight from the count register.
module up_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] cout
);

    // Terminal value; when MODULUS == 2**WIDTH this is all-ones, so the compare
    // folds into the natural overflow.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign cout = count_q;

endmodule

// File: tb/tb_up_counter.sv
// Bench for up_counter: a modulo-16 and a modulo-10 instance share clk/reset and
// are checked against the count of rising edges seen since the last reset release.
`timescale 1ns/1ps
module tb_up_counter;

    logic       clk;
    logic       reset;
    logic [3:0] cout16;
    logic [3:0] cout10;

    int tests;
    int failures;
    int n;          // rising edges seen with reset released

    up_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .cout  (cout16)
    );

    up_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk   (clk),
        .reset (reset),
        .cout  (cout10)
    );

    // 200 ns period, rising edges at 100, 300, 500, ...
    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected values come from edge count alone: n mod MODULUS.
    task automatic check_both(input string tag);
        check({tag, "/m16"}, cout16, 4'(n % 16));
        check({tag, "/m10"}, cout10, 4'(n % 10));
    endtask

    // One rising edge with reset released, then sample 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        n++;
        #1;
        check_both(tag);
    endtask

    initial begin
        int k;
        tests    = 0;
        failures = 0;
        n        = 0;

        // Drive a real falling edge on reset so power-up X is cleared.
        reset = 1'b1;
        #5 reset = 1'b0;

        // Held in reset across edges 100, 300, 500.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_both("hold_reset");
        end

        // Release at 600 ns: 1 at 700, 2 at 900, 3 at 1100.
        #(600 - $time);
        reset = 1'b1;
        n     = 0;
        for (int i = 0; i < 3; i++) step("release");

        // Re-assert between edges at 1200 ns; output clears without a clock.
        #(1200 - $time);
        reset = 1'b0;
        n     = 0;
        #1;
        check_both("async_assert");
        @(posedge clk);
        #1;
        check_both("async_hold");

        // Release at 1400 ns and run past both wrap points.
        #(1400 - $time);
        reset = 1'b1;
        n     = 0;
        for (int i = 0; i < 22; i++) step("wrap_run");

        // Reset falling in the same timestep as a rising edge: reset wins.
        @(posedge clk);
        reset = 1'b0;
        n     = 0;
        #1;
        check_both("coincident");

        // Randomized release points, run lengths and mid-count assertions.
        for (int it = 0; it < 10; it++) begin
            @(negedge clk);
            #($urandom_range(80, 10));
            reset = 1'b1;
            n     = 0;
            k     = int'($urandom_range(35, 3));
            for (int j = 0; j < k; j++) step("rand_run");
            #($urandom_range(80, 10));
            reset = 1'b0;
            n     = 0;
            #1;
            check_both("rand_assert");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
